// File: rtl/kbd_scan.sv
`default_nettype none
// ============================================================================
// Module   : kbd_scan
// Brief    : 4x4 matrix keypad scanner with press/release debounce and hex map.
// Revision : 1.0
// ============================================================================
module kbd_scan #(
  parameter int DWELL_W = 16,
  parameter int DB_MAX  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DB_W = (DB_MAX > 2) ? $clog2(DB_MAX) : 1;
  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DB_MAX - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          row_m_q, row_s_q;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_down_q, key_down_d;

  logic                row_sel_low;
  logic                any_low;
  logic [1:0]          first_low;

  // Row 0 has priority when several rows return low together.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    if (!r[2]) idx = 2'd2;
    if (!r[1]) idx = 2'd1;
    if (!r[0]) idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Idle rows are pulled up, so the synchroniser resets to all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_m_q <= 4'hF;
      row_s_q <= 4'hF;
    end else begin
      row_m_q <= row;
      row_s_q <= row_m_q;
    end
  end

  assign any_low     = ~&row_s_q;
  assign first_low   = lowest_low(row_s_q);
  assign row_sel_low = ~row_s_q[row_idx_q];

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    db_cnt_d    = db_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    case (state_q)
      SCAN: begin
        dwell_d = dwell_q + DWELL_ONE;
        if (&dwell_q) begin
          if (any_low) begin
            row_idx_d = first_low;
            db_cnt_d  = '0;
            state_d   = PRESS_DB;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
      end

      PRESS_DB: begin
        if (row_sel_low) begin
          if (db_cnt_q == DB_LAST) begin
            key_code_d  = key_map(row_idx_q, col_idx_q);
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
            state_d     = HELD;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end else begin
          dwell_d   = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end

      HELD: begin
        if (!row_sel_low) begin
          db_cnt_d = '0;
          state_d  = REL_DB;
        end
      end

      REL_DB: begin
        if (!row_sel_low) begin
          if (db_cnt_q == DB_LAST) begin
            key_down_d = 1'b0;
            dwell_d    = '0;
            col_idx_d  = col_idx_q + 2'd1;
            state_d    = SCAN;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end else begin
          state_d = HELD;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      db_cnt_q    <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
`default_nettype wire

// File: doc/kbd_scan.md
Name: kbd_scan

Overview:
- Scans a 4x4 matrix keypad (Digilent Pmod KYPD layout) by driving active-low column strobes and reading active-low row returns. This is the input-direction counterpart of the time-multiplexed seven-segment display driver.
- Debounces presses and releases, then emits a 4-bit hex key code with a one-cycle valid strobe and a held level.
- Sits between the keypad pins and user logic; typical consumers are the display path and calculator/entry FSMs.

Parameters:
- DWELL_W, 16: column dwell counter width; each column is driven for 2^DWELL_W cycles. Minimum 3.
- DB_MAX, 1000000: consecutive stable cycles required to accept a press or a release (10 ms at 100 MHz). Minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (reset=0 resets)
- row  input  4  keypad row returns; active-low, externally pulled up; asynchronous to clk
- col  output  4  column strobes; active-low one-hot; exactly one bit low at all times
- key_code  output  4  hex code of last accepted key; holds until the next accept
- key_valid  output  1  one-cycle pulse when a debounced press is accepted
- key_down  output  1  high from accept until the debounced release completes

Behaviour:
- Reset values: col=4'b1110 (column 0), key_code=0, key_valid=0, key_down=0, state=SCAN, all counters 0.
- Synchroniser: row passes through a 2-FF synchroniser to give row_s. All decisions use row_s only.
- Dwell counter:
  - Free-runs only in SCAN.
  - Sample point is dwell==all-ones.
  - On the sample point with no row_s bit low, col_idx increments mod 4 (3 wraps to 0) and col updates next cycle.
- SCAN, press detected: at the sample point, if any row_s bit is low:
  - Capture row_idx = lowest-index low bit (row 0 has priority; other simultaneous keys are ignored).
  - Capture col_idx.
  - Clear db_cnt, go to PRESS_DB. The column stays frozen.
- PRESS_DB:
  - Each cycle with row_s[row_idx]==0, db_cnt increments.
  - If row_s[row_idx]==1 on any cycle, abort to SCAN: dwell=0, col_idx+1, no output change.
  - When db_cnt==DB_MAX-1 with the row still low:
    - Next cycle: key_code=map(row_idx,col_idx), key_valid=1 for exactly that cycle, key_down=1.
    - State goes to HELD.
- HELD:
  - Column frozen, key_down=1.
  - row_s[row_idx]==1 clears db_cnt and moves to REL_DB.
  - Other keys pressed while held are ignored.
- REL_DB:
  - Each cycle with row_s[row_idx]==1, db_cnt increments.
  - row_s[row_idx]==0 returns to HELD (bounce; no new key_valid).
  - When db_cnt==DB_MAX-1 with the row still high: next cycle key_down=0, go to SCAN with dwell=0 and col_idx+1.
- Key map (row r, col c, col 0 leftmost):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Press latency: from row pin low to key_valid = 2 sync cycles + wait for this column's sample point + DB_MAX cycles + 1.
- key_valid is never asserted twice per physical press. key_code never changes except in the key_valid cycle.
- Reset asserted mid-operation returns immediately to the reset values; a key still held after reset release is re-detected and re-debounced as a new press.

Test Plan (DWELL_W=3, DB_MAX=8):
- Reset, no keys:
  - col cycles 1110->1101->1011->0111->1110 with 8 cycles per column.
  - key_valid and key_down stay 0.
- Hold row[1] low only while col=1011 (row 1, col 2):
  - Exactly one key_valid pulse with key_code=6 and key_down=1.
  - Release: key_down falls 8+ cycles after row_s goes high; scan resumes at col=0111.
- Press row3/col1 with 3-cycle bounce pulses before stable low:
  - Aborts back to SCAN while bouncing.
  - Final accept gives a single key_valid with key_code=F.
- Hold key 5, then bounce the release 4 times (high<8 cycles, low):
  - key_down stays 1 throughout; no extra key_valid.
  - Clean release then drops key_down.
- Rows 0 and 2 low together on col0:
  - key_code=1 (row 0 wins).
  - Releasing row 0 while row 2 stays low ends HELD; next visit to col0 accepts key 7.
- Drop reset low during PRESS_DB and during HELD:
  - Outputs return to the reset values asynchronously.
  - After reset release with the key still held, a fresh debounce yields one key_valid.
